// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered, handshaked ALU with iterative multiply and divide
// Single-cycle ops finish in one clock; MUL/DIV run N shift-add/restoring steps.
module seq_alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op1,
    input  logic [N-1:0] op2,
    input  logic [3:0]   cmd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic [N-1:0] out_hi,
    output logic         over,
    output logic         under,
    output logic         err,
    output logic         log
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_SHR = 4'd3;
    localparam logic [3:0] OP_EQ  = 4'd4;
    localparam logic [3:0] OP_GT  = 4'd5;
    localparam logic [3:0] OP_LT  = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic [N-1:0]  b_q, b_d;
    logic [2*N:0]  acc_q, acc_d;
    logic [N-1:0]  out_q, out_d, out_hi_q, out_hi_d;
    logic          over_q, over_d, under_q, under_d, err_q, err_d, log_q, log_d;

    logic [N:0]    add_sum;
    logic [N:0]    mul_sum;
    logic [2*N:0]  mul_step;
    logic [2*N:0]  div_sh;
    logic          div_ge;
    logic [2*N:0]  div_step;

    logic          r_write;
    logic [N-1:0]  r_out, r_hi;
    logic          r_over, r_under, r_err, r_log;

    assign add_sum  = {1'b0, op1} + {1'b0, op2};
    // acc = {partial product (N+1), remaining multiplier bits}; LSB selects the add
    assign mul_sum  = acc_q[2*N:N] + (acc_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
    assign mul_step = {1'b0, mul_sum, acc_q[N-1:1]};
    // acc = {partial remainder (N+1), dividend/quotient bits}
    assign div_sh   = {acc_q[2*N-1:0], 1'b0};
    assign div_ge   = div_sh[2*N:N] >= {1'b0, b_q};
    assign div_step = div_ge ? {div_sh[2*N:N] - {1'b0, b_q}, div_sh[N-1:1], 1'b1} : div_sh;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        b_d      = b_q;
        acc_d    = acc_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        over_d   = over_q;
        under_d  = under_q;
        err_d    = err_q;
        log_d    = log_q;
        r_write  = 1'b0;
        r_out    = '0;
        r_hi     = '0;
        r_over   = 1'b0;
        r_under  = 1'b0;
        r_err    = 1'b0;
        r_log    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_write = 1'b1;
                    state_d = DONE;
                    case (cmd)
                        OP_ADD: begin
                            r_out  = add_sum[N-1:0];
                            r_over = add_sum[N];
                        end
                        OP_SUB: begin
                            r_out   = op1 - op2;
                            r_under = op2 > op1;
                        end
                        OP_SHL: r_out = op1 << op2;
                        OP_SHR: r_out = op1 >> op2;
                        OP_EQ:  r_log = op1 == op2;
                        OP_GT:  r_log = op1 > op2;
                        OP_LT:  r_log = op1 < op2;
                        OP_MUL: begin
                            r_write  = 1'b0;
                            state_d  = BUSY;
                            cnt_d    = CNT_LOAD;
                            is_div_d = 1'b0;
                            b_d      = op2;
                            acc_d    = {{(N+1){1'b0}}, op1};
                        end
                        OP_DIV: begin
                            if (op2 == '0) begin
                                r_err = 1'b1;
                                r_out = '1;
                                r_hi  = op1;
                            end else begin
                                r_write  = 1'b0;
                                state_d  = BUSY;
                                cnt_d    = CNT_LOAD;
                                is_div_d = 1'b1;
                                b_d      = op2;
                                acc_d    = {{(N+1){1'b0}}, op1};
                            end
                        end
                        default: r_err = 1'b1;
                    endcase
                end
            end
            BUSY: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q - CNT_ONE;
                // Last step commits straight to the result registers so latency is N+1
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    r_write = 1'b1;
                    r_out   = acc_d[N-1:0];
                    r_hi    = acc_d[2*N-1:N];
                    r_over  = !is_div_q && (acc_d[2*N-1:N] != '0);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (r_write) begin
            out_d    = r_out;
            out_hi_d = r_hi;
            over_d   = r_over;
            under_d  = r_under;
            err_d    = r_err;
            log_d    = r_log;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            err_q    <= 1'b0;
            log_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            over_q   <= over_d;
            under_q  <= under_d;
            err_q    <= err_d;
            log_q    <= log_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign over      = over_q;
    assign under     = under_q;
    assign err       = err_q;
    assign log       = log_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (N=8)
// Arithmetic reference model, per-cycle output compare, directed vectors.
module tb_seq_alu;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] op1 = '0;
    logic [7:0] op2 = '0;
    logic [3:0] cmd = '0;
    logic       in_ready, out_valid;
    logic [7:0] out, out_hi;
    logic       over, under, err, log;

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] h;
        logic       ov;
        logic       un;
        logic       er;
        logic       lg;
    } res_t;

    int         tests = 0;
    int         fails = 0;
    res_t       exp_r = '0;
    bit         exp_valid = 1'b0;
    logic [7:0] r_out, r_hi;
    logic [3:0] r_fl;
    int         r_lat;

    seq_alu #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .cmd(cmd), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_hi(out_hi), .over(over), .under(under), .err(err), .log(log)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        res_t r;
        int unsigned x, y, p;
        r = '0;
        x = a;
        y = b;
        p = 0;
        case (c)
            4'd0: begin p = x + y; r.o = p[7:0]; r.ov = (p > 255); end
            4'd1: begin p = x - y; r.o = p[7:0]; r.un = (y > x); end
            4'd2: begin p = (y >= 8) ? 0 : (x << y); r.o = p[7:0]; end
            4'd3: begin p = (y >= 8) ? 0 : (x >> y); r.o = p[7:0]; end
            4'd4: r.lg = (x == y);
            4'd5: r.lg = (x > y);
            4'd6: r.lg = (x < y);
            4'd7: begin
                p = x * y;
                r.o = p[7:0];
                p = p / 256;
                r.h = p[7:0];
                r.ov = (p != 0);
            end
            4'd8: begin
                if (y == 0) begin
                    r.er = 1'b1;
                    r.o = 8'hFF;
                    r.h = a;
                end else begin
                    p = x / y;
                    r.o = p[7:0];
                    p = x % y;
                    r.h = p[7:0];
                end
            end
            default: r.er = 1'b1;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [7:0] b, input logic [3:0] c);
        return (c == 4'd7 || (c == 4'd8 && b != 0)) ? N + 1 : 1;
    endfunction

    // Every cycle a result is presented it must match the model for the accepted command
    always @(negedge clk) begin
        if (rst_n && exp_valid && out_valid) begin
            check("cmp_out", out, exp_r.o);
            check("cmp_out_hi", out_hi, exp_r.h);
            check("cmp_flags", {over, under, err, log}, {exp_r.ov, exp_r.un, exp_r.er, exp_r.lg});
        end
    end

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input int hold);
        bit seen;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        op1 = a;
        op2 = b;
        cmd = c;
        exp_r = model(a, b, c);
        @(posedge clk);
        #1;
        exp_valid = 1'b1;
        in_valid  = 1'b0;
        op1 = ~a;
        op2 = ~b;
        cmd = c ^ 4'h5;
        r_lat = 0;
        seen  = 1'b0;
        while (!seen && r_lat < 40) begin
            @(negedge clk);
            r_lat++;
            if (out_valid) seen = 1'b1;
            else check("in_ready_busy", in_ready, 0);
        end
        check("latency", r_lat, exp_lat(b, c));
        r_out = out;
        r_hi  = out_hi;
        r_fl  = {over, under, err, log};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op1 = 8'h33;
            op2 = 8'h44;
            cmd = 4'h0;
            check("in_ready_done", in_ready, 0);
            @(negedge clk);
            check("valid_held", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("valid_drop", out_valid, 0);
        check("hold_out", out, exp_r.o);
        check("hold_out_hi", out_hi, exp_r.h);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        check("pin_add", model(8'hFF, 8'h01, 4'd0), {8'h00, 8'h00, 4'b1000});
        check("pin_mul", model(8'h10, 8'h20, 4'd7), {8'h00, 8'h02, 4'b1000});
        check("pin_div0", model(8'h05, 8'h00, 4'd8), {8'hFF, 8'h05, 4'b0010});
        check("pin_sub", model(8'h0F, 8'h10, 4'd1), {8'hFF, 8'h00, 4'b0100});

        repeat (2) @(negedge clk);
        check("rst_out", {out, out_hi}, 16'h0000);
        check("rst_flags", {over, under, err, log}, 4'b0000);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        run(8'hFF, 8'h01, 4'd0, 0);
        check("add_out", r_out, 8'h00);
        check("add_flags", r_fl, 4'b1000);
        check("add_lat", r_lat, 1);
        run(8'h0F, 8'h10, 4'd1, 0);
        check("sub_out", {r_out, r_fl}, {8'hFF, 4'b0100});
        run(8'h0E, 8'h02, 4'd2, 0);
        check("shl_out", r_out, 8'h38);
        run(8'h0F, 8'h09, 4'd3, 0);
        check("shr_out", r_out, 8'h00);
        run(8'h01, 8'h08, 4'd2, 0);
        run(8'h80, 8'h07, 4'd3, 0);
        check("shr7_out", r_out, 8'h01);
        run(8'h10, 8'h20, 4'd7, 0);
        check("mul_res", {r_hi, r_out, r_fl}, {8'h02, 8'h00, 4'b1000});
        check("mul_lat", r_lat, 9);
        run(8'hFF, 8'hFF, 4'd7, 2);
        check("mul_ff", {r_hi, r_out}, 16'hFE01);
        run(8'h03, 8'h05, 4'd7, 0);
        check("mul_small", {r_hi, r_out, r_fl}, {8'h00, 8'h0F, 4'b0000});
        run(8'h05, 8'h00, 4'd8, 0);
        check("div0_res", {r_out, r_hi, r_fl}, {8'hFF, 8'h05, 4'b0010});
        check("div0_lat", r_lat, 1);
        run(8'h07, 8'h09, 4'd8, 0);
        run(8'hFF, 8'h01, 4'd8, 0);
        run(8'h0B, 8'h0B, 4'd5, 0);
        run(8'h0A, 8'h0B, 4'd6, 0);
        check("lt_log", r_fl, 4'b0001);
        run(8'h12, 8'h34, 4'hB, 5);
        check("ill_res", {r_out, r_fl}, {8'h00, 4'b0010});
        run(8'h64, 8'h07, 4'd8, 0);
        check("div_res", {r_out, r_hi}, 16'h0E02);
        check("div_lat", r_lat, 9);

        exp_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        op1 = 8'h10;
        op2 = 8'h20;
        cmd = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", {out, out_hi}, 16'h0000);
        check("midrst_flags", {over, under, err, log}, 4'b0000);
        check("midrst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready", in_ready, 1);
        run(8'h0F, 8'h0F, 4'd4, 0);
        check("eq_log", {r_out, r_fl}, {8'h00, 4'b0001});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
